// File: rtl/mem_access_unit_pkg.sv
//------------------------------------------------------------------------------
// Module   : mem_access_unit_pkg
// Purpose  : Shared access-size codes, constants and state type for the MEM stage.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mem_access_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Low two funct3 bits carry the access size; bit 2 selects zero-extension.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [31:0] ZEROWORD = 32'h0000_0000;
    localparam logic [4:0]  ZEROREG  = 5'd0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mau_state_e;

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_load_formatter.sv
//------------------------------------------------------------------------------
// Module   : load_formatter
// Purpose  : Selects the addressed byte/half of a read word and extends it.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module load_formatter
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_byte_off,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;
    logic        w_signed;

    always_comb begin
        w_shifted = i_rdata >> {i_byte_off, 3'b000};
        w_signed  = ~i_funct3[2];
        case (i_funct3[1:0])
            SZ_B:    o_data = {{24{w_signed & w_shifted[7]}}, w_shifted[7:0]};
            SZ_H:    o_data = {{16{w_signed & w_shifted[15]}}, w_shifted[15:0]};
            default: o_data = w_shifted;  // aligned word: offset is zero
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
//------------------------------------------------------------------------------
// Module   : mem_access_unit
// Purpose  : MEM-stage load/store sequencer with wait states, timeout and alignment checks.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] store_data_i,
    input  logic        RegWrite_i,
    input  logic [4:0]  Rd_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_wstrb_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_ack_i,
    output logic [31:0] load_or_result_o,
    output logic        RegWrite_o,
    output logic [4:0]  Rd_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    // The issue cycle already counts as one stall cycle, so WAIT gives up
    // after TIMEOUT-1 further cycles.
    localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT - 1);

    mau_state_e  r_state;
    mau_state_e  w_next_state;
    logic [7:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;

    logic        w_memop;
    logic        w_misalign;
    logic        w_issue;
    logic        w_wait;
    logic        w_ack;
    logic        w_tmo_hit;
    logic        w_is_load;
    logic [31:0] w_st_wdata;
    logic [3:0]  w_st_wstrb;
    logic [2:0]  w_fmt_f3;
    logic [1:0]  w_fmt_off;
    logic [31:0] w_ld_data;

    assign w_memop    = rst_n & (MemRead_i | MemWrite_i);
    assign w_misalign = is_misaligned(funct3_i, alu_result_i[1:0]);
    assign w_wait     = rst_n & (r_state == ST_WAIT);
    assign w_issue    = (r_state == ST_IDLE) & w_memop & ~w_misalign;
    assign w_ack      = dmem_ack_i & (w_issue | w_wait);
    assign w_tmo_hit  = w_wait & (r_cnt == C_TMO_LAST);

    always_comb begin
        w_st_wdata = store_data_i;
        w_st_wstrb = 4'b1111;
        case (funct3_i[1:0])
            SZ_B: begin
                w_st_wdata = {4{store_data_i[7:0]}};
                w_st_wstrb = 4'b0001 << alu_result_i[1:0];
            end
            SZ_H: begin
                w_st_wdata = {2{store_data_i[15:0]}};
                w_st_wstrb = alu_result_i[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        dmem_req_o   = w_issue | w_wait;
        dmem_we_o    = w_wait ? r_we    : (w_issue & MemWrite_i);
        dmem_addr_o  = w_wait ? r_addr  : {alu_result_i[31:2], 2'b00};
        dmem_wdata_o = w_wait ? r_wdata : w_st_wdata;
        dmem_wstrb_o = w_wait ? r_wstrb : ((w_issue & MemWrite_i) ? w_st_wstrb : 4'b0000);
        w_is_load    = w_wait ? ~r_we    : ~MemWrite_i;
        w_fmt_f3     = w_wait ? r_funct3 : funct3_i;
        w_fmt_off    = w_wait ? r_off    : alu_result_i[1:0];

        load_or_result_o = (w_ack & w_is_load) ? w_ld_data : alu_result_i;
        stall_o          = (w_issue | w_wait) & ~dmem_ack_i & ~w_tmo_hit;
        misalign_o       = (r_state == ST_IDLE) & w_memop & w_misalign;
        bus_err_o        = w_tmo_hit & ~dmem_ack_i;
        Rd_o             = Rd_i;

        if (w_issue | w_wait) begin
            RegWrite_o = w_ack & w_is_load & RegWrite_i;
        end else begin
            RegWrite_o = rst_n & ~w_memop & RegWrite_i;
        end
    end

    load_formatter u_load_formatter (
        .i_rdata    (dmem_rdata_i),
        .i_funct3   (w_fmt_f3),
        .i_byte_off (w_fmt_off),
        .o_data     (w_ld_data)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_issue & ~dmem_ack_i)     w_next_state = ST_WAIT;
            ST_WAIT: if (dmem_ack_i | w_tmo_hit)    w_next_state = ST_IDLE;
            default:                                w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 8'd0;
            r_addr   <= ZEROWORD;
            r_wdata  <= ZEROWORD;
            r_wstrb  <= 4'b0000;
            r_we     <= 1'b0;
            r_funct3 <= F3_B;
            r_off    <= 2'b00;
        end else begin
            r_state <= w_next_state;
            if (w_issue & ~dmem_ack_i) begin
                r_cnt    <= 8'd0;
                r_addr   <= dmem_addr_o;
                r_wdata  <= dmem_wdata_o;
                r_wstrb  <= dmem_wstrb_o;
                r_we     <= dmem_we_o;
                r_funct3 <= funct3_i;
                r_off    <= alu_result_i[1:0];
            end else if (w_wait & ~dmem_ack_i) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_access_unit
// Purpose  : Directed stimulus against a transaction-level model of the MEM stage.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemRead_i = 1'b0, MemWrite_i = 1'b0, RegWrite_i = 1'b0, dmem_ack_i = 1'b0;
    logic [2:0]  funct3_i = 3'b000;
    logic [31:0] alu_result_i = 32'h0, store_data_i = 32'h0, dmem_rdata_i = 32'h0;
    logic [4:0]  Rd_i = 5'd0;
    logic        dmem_req_o, dmem_we_o, RegWrite_o, stall_o, misalign_o, bus_err_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, load_or_result_o;
    logic [3:0]  dmem_wstrb_o;
    logic [4:0]  Rd_o;

    int n_chk = 0;
    int n_err = 0;

    mem_access_unit #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .funct3_i(funct3_i),
        .alu_result_i(alu_result_i), .store_data_i(store_data_i),
        .RegWrite_i(RegWrite_i), .Rd_i(Rd_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o),
        .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i),
        .load_or_result_o(load_or_result_o), .RegWrite_o(RegWrite_o), .Rd_o(Rd_o),
        .stall_o(stall_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [2:0] f3,
                                               input logic [1:0] off);
        logic [31:0] v;
        v = rd >> (8 * int'(off));
        if (size_of(f3) == 1) begin
            v = v & 32'hFF;
            if (!f3[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (size_of(f3) == 2) begin
            v = v & 32'hFFFF;
            if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] sd, input logic [2:0] f3);
        if (size_of(f3) == 1) return (sd & 32'hFF) * 32'h0101_0101;
        if (size_of(f3) == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [3:0] model_wstrb(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] m;
        m = 4'((1 << size_of(f3)) - 1);
        return m << off;
    endfunction

    // Pending-access state: m_stalls counts stall cycles already spent on it.
    logic        m_busy = 1'b0, n_busy = 1'b0;
    int          m_stalls = 0, n_stalls = 0;
    logic        m_we = 1'b0, n_we = 1'b0;
    logic [31:0] m_addr = 32'h0, n_addr = 32'h0, m_wd = 32'h0, n_wd = 32'h0;
    logic [3:0]  m_strb = 4'h0, n_strb = 4'h0;
    logic [2:0]  m_f3 = 3'h0, n_f3 = 3'h0;
    logic [1:0]  m_off = 2'h0, n_off = 2'h0;

    logic        e_req, e_we, e_rw, e_stall, e_mis, e_berr;
    logic [31:0] e_addr, e_wd, e_res;
    logic [3:0]  e_strb;

    always @(posedge clk) begin
        m_busy   <= n_busy;
        m_stalls <= n_stalls;
        m_we     <= n_we;
        m_addr   <= n_addr;
        m_wd     <= n_wd;
        m_strb   <= n_strb;
        m_f3     <= n_f3;
        m_off    <= n_off;
    end

    always @(negedge clk) begin
        e_req = 0; e_we = 0; e_rw = 0; e_stall = 0; e_mis = 0; e_berr = 0;
        e_addr = 0; e_wd = 0; e_strb = 0; e_res = alu_result_i;
        n_busy = m_busy; n_stalls = m_stalls; n_we = m_we; n_addr = m_addr;
        n_wd = m_wd; n_strb = m_strb; n_f3 = m_f3; n_off = m_off;
        if (!rst_n) begin
            n_busy = 0;
        end else if (m_busy) begin
            e_req = 1; e_we = m_we; e_addr = m_addr; e_wd = m_wd; e_strb = m_strb;
            if (dmem_ack_i) begin
                n_busy = 0;
                if (!m_we) begin
                    e_res = model_load(dmem_rdata_i, m_f3, m_off);
                    e_rw  = RegWrite_i;
                end
            end else if (m_stalls == TMO) begin
                e_berr = 1;
                n_busy = 0;
            end else begin
                e_stall  = 1;
                n_stalls = m_stalls + 1;
            end
        end else if (MemRead_i || MemWrite_i) begin
            if ((int'(alu_result_i[1:0]) % size_of(funct3_i)) != 0) begin
                e_mis = 1;
            end else begin
                e_req  = 1;
                e_we   = MemWrite_i;
                e_addr = alu_result_i & 32'hFFFF_FFFC;
                e_wd   = model_wdata(store_data_i, funct3_i);
                e_strb = model_wstrb(funct3_i, alu_result_i[1:0]);
                if (dmem_ack_i) begin
                    if (!MemWrite_i) begin
                        e_res = model_load(dmem_rdata_i, funct3_i, alu_result_i[1:0]);
                        e_rw  = RegWrite_i;
                    end
                end else begin
                    e_stall = 1;
                    n_busy = 1; n_stalls = 1; n_we = e_we; n_addr = e_addr;
                    n_wd = e_wd; n_strb = e_strb; n_f3 = funct3_i; n_off = alu_result_i[1:0];
                end
            end
        end else begin
            e_rw = RegWrite_i;
        end

        chk("req", dmem_req_o, e_req);
        chk("stall", stall_o, e_stall);
        chk("misalign", misalign_o, e_mis);
        chk("bus_err", bus_err_o, e_berr);
        chk("regwrite", RegWrite_o, e_rw);
        chk("rd", Rd_o, Rd_i);
        if (e_req) begin
            chk("addr", dmem_addr_o, e_addr);
            chk("we", dmem_we_o, e_we);
        end
        if (e_req && e_we) begin
            chk("wdata", dmem_wdata_o, e_wd);
            chk("wstrb", dmem_wstrb_o, e_strb);
        end
        if (!e_stall) chk("result", load_or_result_o, e_res);
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic rst, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic rw,
                        input logic [4:0] rdi, input logic ack, input logic [31:0] rdata);
        @(posedge clk);
        #1;
        rst_n = rst; MemRead_i = rd; MemWrite_i = wr; funct3_i = f3;
        alu_result_i = a; store_data_i = sd; RegWrite_i = rw; Rd_i = rdi;
        dmem_ack_i = ack; dmem_rdata_i = rdata;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1, 0, 0, 3'b010, 32'h0000_0040, 0, 0, 5'd0, 0, 0);
    endtask

    initial begin
        // Reset with a pending-looking request on the inputs
        step(0, 1, 0, 3'b010, 32'h100, 0, 1, 5'd3, 0, 0);
        step(0, 1, 0, 3'b010, 32'h100, 0, 1, 5'd3, 0, 0);
        chk("lit_rst_req", dmem_req_o, 0);
        chk("lit_rst_stall", stall_o, 0);
        chk("lit_rst_rw", RegWrite_o, 0);

        // ALU op with a stray ack
        step(1, 0, 0, 3'b010, 32'h1234_5678, 0, 1, 5'd5, 1, 32'hFFFF_FFFF);
        chk("lit_alu_res", load_or_result_o, 32'h1234_5678);
        chk("lit_alu_rw", RegWrite_o, 1);

        // LW zero-wait
        step(1, 1, 0, 3'b010, 32'h100, 0, 1, 5'd7, 1, 32'hDEAD_BEEF);
        chk("lit_lw_stall", stall_o, 0);
        chk("lit_lw_res", load_or_result_o, 32'hDEAD_BEEF);
        chk("lit_lw_rw", RegWrite_o, 1);

        // LB with two wait cycles
        step(1, 1, 0, 3'b000, 32'h103, 0, 1, 5'd8, 0, 32'h8011_2233);
        chk("lit_lb_stall0", stall_o, 1);
        step(1, 1, 0, 3'b000, 32'h103, 0, 1, 5'd8, 0, 32'h8011_2233);
        chk("lit_lb_stall1", stall_o, 1);
        step(1, 1, 0, 3'b000, 32'h103, 0, 1, 5'd8, 1, 32'h8011_2233);
        chk("lit_lb_stall2", stall_o, 0);
        chk("lit_lb_res", load_or_result_o, 32'hFFFF_FF80);

        // SH upper half
        step(1, 0, 1, 3'b001, 32'h202, 32'h0000_ABCD, 1, 5'd9, 1, 0);
        chk("lit_sh_wdata", dmem_wdata_o, 32'hABCD_ABCD);
        chk("lit_sh_wstrb", dmem_wstrb_o, 4'b1100);
        chk("lit_sh_we", dmem_we_o, 1);
        chk("lit_sh_rw", RegWrite_o, 0);

        // Misaligned LW
        step(1, 1, 0, 3'b010, 32'h102, 0, 1, 5'd10, 0, 0);
        chk("lit_mis", misalign_o, 1);
        chk("lit_mis_req", dmem_req_o, 0);
        chk("lit_mis_stall", stall_o, 0);
        idle();
        chk("lit_mis_clear", misalign_o, 0);

        // Other load formats
        step(1, 1, 0, 3'b100, 32'h101, 0, 1, 5'd11, 1, 32'h1122_8344);
        chk("lit_lbu", load_or_result_o, 32'h0000_0083);
        step(1, 1, 0, 3'b001, 32'h102, 0, 1, 5'd12, 1, 32'h9ABC_1234);
        chk("lit_lh", load_or_result_o, 32'hFFFF_9ABC);
        step(1, 1, 0, 3'b101, 32'h100, 0, 1, 5'd13, 1, 32'h9ABC_1234);
        chk("lit_lhu", load_or_result_o, 32'h0000_1234);

        // SB with one wait, then SW with both request flags high
        step(1, 0, 1, 3'b000, 32'h203, 32'h0000_005A, 1, 5'd14, 0, 0);
        step(1, 0, 1, 3'b000, 32'h203, 32'h0000_005A, 1, 5'd14, 1, 0);
        chk("lit_sb_wdata", dmem_wdata_o, 32'h5A5A_5A5A);
        chk("lit_sb_wstrb", dmem_wstrb_o, 4'b1000);
        step(1, 1, 1, 3'b010, 32'h204, 32'hCAFE_F00D, 1, 5'd15, 1, 32'h1111_1111);
        chk("lit_sw_we", dmem_we_o, 1);
        chk("lit_sw_rw", RegWrite_o, 0);
        step(1, 1, 0, 3'b001, 32'h201, 0, 1, 5'd16, 0, 0);
        idle();

        // Timeout: four stall cycles, then bus error
        for (int i = 0; i < TMO; i++) begin
            step(1, 1, 0, 3'b010, 32'h300, 0, 1, 5'd17, 0, 0);
            chk("lit_tmo_stall", stall_o, 1);
        end
        step(1, 1, 0, 3'b010, 32'h300, 0, 1, 5'd17, 0, 0);
        chk("lit_tmo_berr", bus_err_o, 1);
        chk("lit_tmo_stall_rel", stall_o, 0);
        chk("lit_tmo_rw", RegWrite_o, 0);
        idle();
        chk("lit_tmo_idle_req", dmem_req_o, 0);

        // Ack arriving in the timeout cycle wins
        for (int i = 0; i < TMO; i++) step(1, 1, 0, 3'b010, 32'h304, 0, 1, 5'd18, 0, 0);
        step(1, 1, 0, 3'b010, 32'h304, 0, 1, 5'd18, 1, 32'h55AA_55AA);
        chk("lit_tmoack_berr", bus_err_o, 0);
        chk("lit_tmoack_res", load_or_result_o, 32'h55AA_55AA);
        idle();

        // Reset while waiting
        step(1, 0, 1, 3'b010, 32'h400, 32'h0BAD_F00D, 0, 5'd19, 0, 0);
        chk("lit_rw_stall", stall_o, 1);
        step(0, 0, 1, 3'b010, 32'h400, 32'h0BAD_F00D, 0, 5'd19, 0, 0);
        idle();
        chk("lit_rstw_req", dmem_req_o, 0);
        chk("lit_rstw_stall", stall_o, 0);
        chk("lit_rstw_berr", bus_err_o, 0);
        step(1, 1, 0, 3'b010, 32'h104, 0, 1, 5'd20, 1, 32'h0F0F_0F0F);
        chk("lit_post_rst", load_or_result_o, 32'h0F0F_0F0F);
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning maximum wait cycles for dmem_ack_i before abort (1..255).
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 MemRead_i / MemWrite_i  input  1 each  load / store request from EX/MEM.
REQ-005 funct3_i  input  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-006 alu_result_i  input  32  effective address, or ALU result for non-memory instructions.
REQ-007 store_data_i  input  32  rs2 value for stores.
REQ-008 RegWrite_i  input  1  and Rd_i  input  5  writeback control from EX/MEM.
REQ-009 dmem_req_o  output  1  bus request; dmem_we_o  output  1  write enable.
REQ-010 dmem_addr_o  output  32  word-aligned address, bits[1:0] = 0.
REQ-011 dmem_wdata_o  output  32  lane-shifted store data; dmem_wstrb_o  output  4  byte strobes.
REQ-012 dmem_rdata_i  input  32  read data; dmem_ack_i  input  1  completion, valid in any cycle with req high.
REQ-013 load_or_result_o  output  32  and RegWrite_o  output  1  and Rd_o  output  5  toward MEM/WB register.
REQ-014 stall_o  output  1  holds IF..EX/MEM while the access is pending.
REQ-015 misalign_o / bus_err_o  output  1 each  one-cycle exception pulses.

Function
REQ-016 The FSM SHALL have states IDLE and WAIT.
REQ-017 memop = MemRead_i | MemWrite_i; both high SHALL be treated as a store.
REQ-018 Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0; no request issued, misalign_o high for that cycle, RegWrite_o=0, stall_o=0.
REQ-019 IDLE, aligned memop: dmem_req_o=1 combinationally; address, wdata, wstrb and we SHALL be latched into request registers at the same edge the FSM moves to WAIT (when ack_i=0).
REQ-020 In WAIT, bus outputs SHALL be driven from the request registers and dmem_req_o SHALL stay 1 until ack.
REQ-021 stall_o = (IDLE & aligned memop & !dmem_ack_i) | (WAIT & !dmem_ack_i & !timeout); zero-wait ack SHALL cause no stall.
REQ-022 On ack (IDLE or WAIT): FSM -> IDLE, stall_o=0 that cycle, and for loads load_or_result_o is the formatted dmem_rdata_i.
REQ-023 Load formatting: byte/half selected by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W passes through.
REQ-024 Store formatting: SB replicates byte to all lanes with wstrb = 1<<addr[1:0]; SH replicates half with wstrb 0011/1100; SW wstrb 1111.
REQ-025 Wait counter SHALL clear on entry to WAIT and increment each WAIT cycle without ack; count==TIMEOUT SHALL pulse bus_err_o, force RegWrite_o=0, release stall_o, and return to IDLE.
REQ-026 Non-memop: load_or_result_o=alu_result_i and RegWrite_o=RegWrite_i with zero latency; stores SHALL force RegWrite_o=0.
REQ-027 Rd_o SHALL equal Rd_i in all cases.
REQ-028 ack in the same cycle as timeout SHALL be treated as ack; no bus_err_o.
REQ-029 dmem_ack_i while in IDLE with no request SHALL be ignored.

Reset
REQ-030 rst_n=0 at posedge SHALL force IDLE, clear counter and request registers; dmem_req_o, stall_o, misalign_o, bus_err_o, RegWrite_o = 0 in the following cycle.
REQ-031 Reset mid-WAIT SHALL abandon the access without a bus_err_o pulse.

Structure
REQ-032 funct3 size codes and zeroword/zeroreg constants SHALL live in the shared define file.
REQ-033 Load extraction/extension SHALL be a combinational sub-module load_formatter.

Verification
REQ-034 LW addr 0x100, ack same cycle, rdata 0xDEADBEEF -> no stall, result 0xDEADBEEF, RegWrite_o=1.
REQ-035 LB addr 0x103, rdata 0x80112233, 2 wait cycles -> stall_o high 2 cycles, result 0xFFFFFF80.
REQ-036 SH addr 0x202, data 0x0000ABCD -> wdata 0xABCDABCD, wstrb 1100, we=1, RegWrite_o=0.
REQ-037 LW addr 0x102 -> misalign_o one cycle, dmem_req_o=0, stall_o=0.
REQ-038 TIMEOUT=4, no ack -> stall_o 4 cycles, bus_err_o pulse, RegWrite_o=0, then IDLE.
REQ-039 rst_n low during WAIT -> next cycle req and stall 0, no bus_err_o.
